// File: rtl/sq_iter_ctrl.sv
// -----------------------------------------------------------------------------
// sq_iter_ctrl
//
// Sequencer for the modular-squaring loop. A single enable token walks the
// PIPE_DEPTH registered stages of the carry-save accumulation/reduction
// datapath. One full walk of the token is one squaring. The operand is loaded
// once from outside. After that, each squaring's result is fed back into stage 0
// until the programmed number of squarings has completed.
//
// Optional feature: define SQ_ITER_CHKPT_EN to add the chkpt output. That output
// pulses every 2^CHKPT_LOG2 completed squarings, so that external logic can
// snapshot the feedback operand.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        one-cycle run request, accepted only when idle
//   abort        cancels a run in progress (load or run phase)
//   iter_target  number of squarings, sampled on the accepted start
//   busy         high while the operand is loading or squarings are running
//   done         one-cycle completion pulse
//   sel_load     1: stage 0 takes the external operand, 0: feedback
//   stage_en     one-hot stage register enable
//   capture      latch the final result (with done, nonzero runs only)
//   iter_done    completed squarings in the current or last run
//   chkpt        checkpoint pulse (only with SQ_ITER_CHKPT_EN)
//
// PIPE_DEPTH must lie in 2..32.
// -----------------------------------------------------------------------------
module sq_iter_ctrl #(
  parameter int PIPE_DEPTH = 6,
  parameter int ITER_W     = 64
`ifdef SQ_ITER_CHKPT_EN
  ,
  parameter int CHKPT_LOG2 = 20
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_W-1:0]     iter_target,
  output logic                  busy,
  output logic                  done,
  output logic                  sel_load,
  output logic [PIPE_DEPTH-1:0] stage_en,
  output logic                  capture,
  output logic [ITER_W-1:0]     iter_done
`ifdef SQ_ITER_CHKPT_EN
  ,
  output logic                  chkpt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [PIPE_DEPTH-1:0] STAGE0 = {{(PIPE_DEPTH-1){1'b0}}, 1'b1};
  localparam logic [PIPE_DEPTH-1:0] NONE   = {PIPE_DEPTH{1'b0}};

  state_t                  state_q, state_d;
  logic [ITER_W-1:0]       target_q, target_d;
  logic [ITER_W-1:0]       iter_done_q, iter_done_d;
  logic [PIPE_DEPTH-1:0]   stage_en_q, stage_en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    sel_load_q, sel_load_d;
  logic                    capture_q, capture_d;
`ifdef SQ_ITER_CHKPT_EN
  logic                    chkpt_q, chkpt_d;
`endif

  logic [ITER_W-1:0]       iter_next_s;
  logic                    last_stage_s;
  logic                    final_iter_s;

  // The final squaring is detected by comparing the current count against
  // target-1. This is done before the increment, so a target of all-ones can
  // never make the counter wrap. In the run states the target is never zero.
  assign iter_next_s  = iter_done_q + {{(ITER_W-1){1'b0}}, 1'b1};
  assign last_stage_s = stage_en_q[PIPE_DEPTH-1];
  assign final_iter_s = (iter_done_q == (target_q - {{(ITER_W-1){1'b0}}, 1'b1}));

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered, so that they register in the same cycle as that state.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    iter_done_d = iter_done_q;
    stage_en_d  = NONE;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    sel_load_d  = 1'b0;
    capture_d   = 1'b0;
`ifdef SQ_ITER_CHKPT_EN
    chkpt_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          iter_done_d = {ITER_W{1'b0}};
          if (iter_target != {ITER_W{1'b0}}) begin
            target_d   = iter_target;
            state_d    = ST_LOAD;
            stage_en_d = STAGE0;
            sel_load_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            // A zero-length run completes at once, with nothing to capture.
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD, ST_RUN: begin
        if (abort) begin
          // Abort takes priority, even over the final squaring.
          state_d = ST_IDLE;
        end else if (last_stage_s) begin
          iter_done_d = iter_next_s;
          if (final_iter_s) begin
            state_d   = ST_FIN;
            done_d    = 1'b1;
            capture_d = 1'b1;
          end else begin
            // Feedback: the token re-enters stage 0 without a bubble.
            state_d    = ST_RUN;
            stage_en_d = STAGE0;
            busy_d     = 1'b1;
`ifdef SQ_ITER_CHKPT_EN
            chkpt_d    = (iter_next_s[CHKPT_LOG2-1:0] == {CHKPT_LOG2{1'b0}});
`endif
          end
        end else begin
          state_d    = ST_RUN;
          stage_en_d = {stage_en_q[PIPE_DEPTH-2:0], 1'b0};
          busy_d     = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      target_q    <= {ITER_W{1'b0}};
      iter_done_q <= {ITER_W{1'b0}};
      stage_en_q  <= NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sel_load_q  <= 1'b0;
      capture_q   <= 1'b0;
`ifdef SQ_ITER_CHKPT_EN
      chkpt_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      iter_done_q <= iter_done_d;
      stage_en_q  <= stage_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sel_load_q  <= sel_load_d;
      capture_q   <= capture_d;
`ifdef SQ_ITER_CHKPT_EN
      chkpt_q     <= chkpt_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sel_load  = sel_load_q;
  assign stage_en  = stage_en_q;
  assign capture   = capture_q;
  assign iter_done = iter_done_q;
`ifdef SQ_ITER_CHKPT_EN
  assign chkpt     = chkpt_q;
`endif

endmodule

// File: tb/tb_sq_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sq_iter_ctrl
//
// Self-checking bench for sq_iter_ctrl. The reference model tracks only three
// things: whether a run is active, how many cycles have passed since the start
// was accepted, and the target. It derives every expected output arithmetically
// from that cycle index. Directed runs pin the model to hand-computed cycle
// numbers. After them, a long randomized stream of start/abort/reset activity
// follows.
// -----------------------------------------------------------------------------
module tb_sq_iter_ctrl;

  localparam int P  = 6;
  localparam int W  = 64;
  localparam int CH = 4;   // checkpoint interval 2^2, used with SQ_ITER_CHKPT_EN

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [W-1:0]  iter_target;
  logic          busy, done, sel_load, capture;
  logic [P-1:0]  stage_en;
  logic [W-1:0]  iter_done;
`ifdef SQ_ITER_CHKPT_EN
  logic          chkpt;
`endif

  sq_iter_ctrl #(
    .PIPE_DEPTH(P),
    .ITER_W(W)
`ifdef SQ_ITER_CHKPT_EN
    ,
    .CHKPT_LOG2(2)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .iter_target(iter_target),
    .busy(busy),
    .done(done),
    .sel_load(sel_load),
    .stage_en(stage_en),
    .capture(capture),
    .iter_done(iter_done)
`ifdef SQ_ITER_CHKPT_EN
    ,
    .chkpt(chkpt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: mode, cycle index within the run (1 = load cycle), target.
  typedef enum {M_IDLE, M_RUN, M_FIN} mmode_t;
  mmode_t          m_mode = M_IDLE;
  longint unsigned m_k    = 0;
  longint unsigned m_n    = 0;
  longint unsigned m_last = 0;
  bit              m_cap  = 1'b0;

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Advance the model by one clock edge, given the inputs sampled at that edge.
  task automatic model_next(input bit r, input bit s, input bit a, input logic [W-1:0] t);
    if (r) begin
      m_mode = M_IDLE;
      m_last = 0;
    end else begin
      case (m_mode)
        M_RUN: begin
          if (a) begin
            m_mode = M_IDLE;
            m_last = (m_k - 1) / P;
          end else if ((m_k % P == 0) && (m_k / P == m_n)) begin
            m_mode = M_FIN;
            m_cap  = 1'b1;
            m_last = m_n;
          end else begin
            m_k++;
          end
        end
        M_FIN: m_mode = M_IDLE;
        default: begin
          if (s) begin
            if (t != 0) begin
              m_mode = M_RUN;
              m_k    = 1;
              m_n    = t;
            end else begin
              m_mode = M_FIN;
              m_cap  = 1'b0;
              m_last = 0;
            end
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs, clock, then compare every output to the model.
  task automatic step(input bit r, input bit s, input bit a, input logic [W-1:0] t);
    logic          e_busy, e_done, e_sel, e_cap, e_chk;
    logic [P-1:0]  e_stage;
    logic [W-1:0]  e_it;
    reset = r; start = s; abort = a; iter_target = t;
    model_next(r, s, a, t);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e_busy = 1'b0; e_done = 1'b0; e_sel = 1'b0; e_cap = 1'b0; e_chk = 1'b0;
    e_stage = '0; e_it = m_last;
    if (m_mode == M_RUN) begin
      e_busy  = 1'b1;
      e_stage = P'(1) << ((m_k - 1) % P);
      e_sel   = (m_k == 1);
      e_it    = (m_k - 1) / P;
      e_chk   = (m_k > 1) && ((m_k - 1) % P == 0) && ((((m_k - 1) / P) % CH) == 0);
    end else if (m_mode == M_FIN) begin
      e_done = 1'b1;
      e_cap  = m_cap;
    end
    check1("busy",      64'(busy),      64'(e_busy));
    check1("done",      64'(done),      64'(e_done));
    check1("sel_load",  64'(sel_load),  64'(e_sel));
    check1("stage_en",  64'(stage_en),  64'(e_stage));
    check1("capture",   64'(capture),   64'(e_cap));
    check1("iter_done", iter_done,      e_it);
`ifdef SQ_ITER_CHKPT_EN
    check1("chkpt",     64'(chkpt),     64'(e_chk));
`endif
  endtask

  initial begin
    int done_at;
    int r_sel;
    logic [W-1:0] tg;
    reset = 1'b1; start = 1'b0; abort = 1'b0; iter_target = '0;
    @(negedge clk);

    // Reset, then ten idle cycles.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    check1("pin_idle_stage_en", 64'(stage_en), 64'd0);

    // Three squarings, with start pulses that must be ignored.
    step(0, 1, 0, 3);
    check1("pin_sel_load_t1", 64'(sel_load), 64'd1);
    done_at = -1;
    for (int j = 1; j <= 19; j++) begin
      step(0, (j == 5 || j == 19), 0, 0);
      if (done === 1'b1 && done_at < 0) begin
        done_at = j + 1;
        check1("pin_final_count", iter_done, 64'd3);
        check1("pin_final_capture", 64'(capture), 64'd1);
      end
    end
    check1("pin_done_cycle", 64'(done_at), 64'd19);
    check1("pin_no_second_run", 64'(busy), 64'd0);

    // Zero-length run.
    step(0, 1, 0, 0);
    check1("pin_zero_done", 64'(done), 64'd1);
    check1("pin_zero_capture", 64'(capture), 64'd0);
    check1("pin_zero_count", iter_done, 64'd0);
    step(0, 0, 0, 0);

    // Abort in the fourth squaring of a ten-squaring run, then a fresh start.
    step(0, 1, 0, 10);
    for (int j = 1; j <= 20; j++) step(0, 0, (j == 20), 0);
    check1("pin_abort_busy", 64'(busy), 64'd0);
    check1("pin_abort_count", iter_done, 64'd3);
    check1("pin_abort_stage_en", 64'(stage_en), 64'd0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 2);
    check1("pin_restart_count", iter_done, 64'd0);
    check1("pin_restart_sel", 64'(sel_load), 64'd1);
    for (int j = 0; j < 14; j++) step(0, 0, 0, 0);

    // Largest legal target: run a while, then abort.
    step(0, 1, 0, {W{1'b1}});
    for (int j = 1; j <= 13; j++) step(0, 0, (j == 13), 0);
    check1("pin_max_abort_count", iter_done, 64'd2);

    // Reset in the middle of a run.
    step(0, 1, 0, 5);
    for (int j = 0; j < 7; j++) step(0, 0, 0, 0);
    step(1, 1, 1, 0);
    check1("pin_reset_busy", 64'(busy), 64'd0);
    check1("pin_reset_count", iter_done, 64'd0);
    step(0, 0, 0, 0);

`ifdef SQ_ITER_CHKPT_EN
    // Checkpoint pulses after squarings 4 and 8, none after the last one.
    begin
      int n_chk, first_chk, second_chk;
      n_chk = 0; first_chk = -1; second_chk = -1; done_at = -1;
      step(0, 1, 0, 9);
      for (int j = 1; j <= 56; j++) begin
        step(0, 0, 0, 0);
        if (chkpt === 1'b1) begin
          n_chk++;
          if (first_chk < 0) first_chk = j + 1;
          else if (second_chk < 0) second_chk = j + 1;
        end
        if (done === 1'b1 && done_at < 0) done_at = j + 1;
      end
      check1("pin_chkpt_count", 64'(n_chk), 64'd2);
      check1("pin_chkpt_first", 64'(first_chk), 64'd25);
      check1("pin_chkpt_second", 64'(second_chk), 64'd49);
      check1("pin_chkpt_done", 64'(done_at), 64'd55);
    end
`endif

    // Randomized start/abort/reset traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      r_sel = $urandom_range(0, 9);
      if (r_sel == 0)      tg = '0;
      else if (r_sel == 1) tg = {$urandom, $urandom};
      else                 tg = W'($urandom_range(1, 6));
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 39) == 0), tg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sq_iter_ctrl.md
Name: sq_iter_ctrl

Overview:
- Sequencer for the modular-squaring loop built around the 130-limb carry-save accumulation/reduction datapath.
- Loads an initial operand, then recirculates it through a PIPE_DEPTH-stage datapath for a programmed 64-bit number of squarings.
- Drives per-stage register enables, the load/feedback operand mux select and result capture.
- Reports progress and completion through a start/busy/done handshake.

Parameters:
- PIPE_DEPTH, 6, number of registered datapath stages per squaring (partial products through accumulation and reduction); legal range 2..32.
- ITER_W, 64, width of the iteration target and counter.
- CHKPT_LOG2, 20, checkpoint interval is 2^CHKPT_LOG2 iterations (used only with the optional feature).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  cancel the current run; sampled in LOAD/RUN.
- iter_target  input  ITER_W  number of squarings; sampled on the accepted start.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle completion pulse.
- sel_load  output  1  1 = datapath stage 0 takes the external operand; 0 = feedback of the previous result.
- stage_en  output  PIPE_DEPTH  one-hot stage register enable.
- capture  output  1  latch the final result; coincident with done on a nonzero run.
- iter_done  output  ITER_W  completed squarings in the current or last run.

Behaviour:
- Reset values: state IDLE; busy=0, done=0, sel_load=0, stage_en=0, capture=0, iter_done=0, chkpt=0. Reset mid-run wins over every other input.
- All outputs are registered.
- States: IDLE, LOAD, RUN, FIN.
- IDLE, start=1, iter_target!=0: next state LOAD. Latch the target; clear iter_done.
- IDLE, start=1, iter_target==0: next state FIN. Clear iter_done. In FIN: done=1, capture=0, stage_en stays 0.
- LOAD (1 cycle): sel_load=1, stage_en=1 (bit 0), busy=1. Next state RUN.
- RUN: the enable token shifts one bit per cycle, stage_en[k] one cycle after stage_en[k-1]. sel_load=0.
- Iteration complete: a cycle with stage_en[PIPE_DEPTH-1]=1 completes an iteration. iter_done increments at that edge.
- After a completed iteration, if the new count == target: next state FIN, stage_en=0, done=1, capture=1.
- After a completed iteration, otherwise: stage_en[0]=1 on the next cycle (feedback); the token re-enters with no bubble.
- Iteration period is exactly PIPE_DEPTH cycles.
- Timing: if start is sampled at edge t0, done is asserted in cycle t0 + N*PIPE_DEPTH + 1.
- FIN lasts 1 cycle, then IDLE. busy=0 in FIN and IDLE.
- start in LOAD/RUN/FIN: ignored; no queuing.
- abort in LOAD/RUN: next cycle is IDLE with stage_en=0. No done, no capture. iter_done holds its value.
- abort and the final iteration in the same cycle: abort wins.
- start and abort together in IDLE: start is accepted; abort is ignored.
- iter_target = 2^ITER_W-1 is legal. The counter never wraps, because completion is detected by equality before the increment would overflow.

Optional Feature:
- Macro: SQ_ITER_CHKPT_EN.
- When defined: extra output port chkpt (1 bit, registered).
  - chkpt pulses for 1 cycle, concurrent with stage_en[0] of the next iteration, whenever a completed iteration leaves iter_done[CHKPT_LOG2-1:0]==0 and the run is not finishing.
  - The external logic snapshots the feedback operand on that pulse.
  - chkpt is never asserted in FIN or after abort.
- When undefined: no chkpt port and no related logic; behaviour is otherwise identical.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, stage_en=0.
- PIPE_DEPTH=6, start with iter_target=3 at t0 -> sel_load=1 only at t0+1; stage_en one-hot walks bits 0..5 three times with no gap; iter_done reaches 1,2,3; done=capture=1 at t0+19 only; busy high t0+1..t0+18.
- iter_target=0 -> done=1 at t0+1, capture=0, stage_en never nonzero, iter_done=0.
- iter_target=10, abort asserted at t0+20 -> IDLE at t0+21, stage_en=0, no done/capture, iter_done=3. A start at t0+22 begins a fresh run with iter_done cleared.
- start pulses at t0+5 and t0+19 during an iter_target=3 run (done at t0+19) -> both ignored; state IDLE at t0+20 with no second run.
- SQ_ITER_CHKPT_EN with CHKPT_LOG2=2, iter_target=9 -> chkpt pulses after iterations 4 and 8 (cycles t0+25, t0+49); no pulse after iteration 9; done at t0+55.
